// File: rtl/pipe_issue_ctrl.sv
// rtl/pipe_issue_ctrl.sv - issue controller with RAW scoreboard, illegal-op drop and halt/drain
// Stalls read-after-write hazards for a 3-stage pipeline without forwarding.
module pipe_issue_ctrl #(
  parameter int SAT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_func,
  input  logic [3:0]       in_rd,
  input  logic [3:0]       in_rs1,
  input  logic [3:0]       in_rs2,
  input  logic [7:0]       in_addr,
  input  logic             halt,
  output logic             iss_valid,
  output logic [3:0]       iss_func,
  output logic [3:0]       iss_rd,
  output logic [3:0]       iss_rs1,
  output logic [3:0]       iss_rs2,
  output logic [7:0]       iss_addr,
  output logic             illegal,
  output logic             done,
  output logic [SAT_W-1:0] issue_cnt,
  output logic [SAT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t     state;
  logic [1:0] drain_cnt;
  logic       s1_v, s2_v;
  logic [3:0] s1_rd, s2_rd;

  logic use_rs1, use_rs2, legal, hazard, accept, stall_evt;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (in_func)
      4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      4'd3, 4'd8, 4'd10, 4'd11: use_rs1 = 1'b1;
      4'd4, 4'd9:               use_rs2 = 1'b1;
      default: ;
    endcase
  end

  // Register r0 is an ordinary register here, so no index is exempt from matching.
  assign hazard = (use_rs1 && ((s1_v && s1_rd == in_rs1) || (s2_v && s2_rd == in_rs1))) ||
                  (use_rs2 && ((s1_v && s1_rd == in_rs2) || (s2_v && s2_rd == in_rs2)));

  assign legal     = (in_func < 4'd12);
  assign in_ready  = (state == RUN) && !halt && !hazard;
  assign accept    = in_valid && in_ready;
  assign stall_evt = (state == RUN) && in_valid && !halt && hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s1_rd     <= 4'd0;
      s2_rd     <= 4'd0;
      iss_valid <= 1'b0;
      iss_func  <= 4'd0;
      iss_rd    <= 4'd0;
      iss_rs1   <= 4'd0;
      iss_rs2   <= 4'd0;
      iss_addr  <= 8'd0;
      illegal   <= 1'b0;
      done      <= 1'b0;
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      s2_v  <= s1_v;
      s2_rd <= s1_rd;
      s1_v  <= accept && legal;
      iss_valid <= accept && legal;

      if (accept && legal) begin
        s1_rd    <= in_rd;
        iss_func <= in_func;
        iss_rd   <= in_rd;
        iss_rs1  <= in_rs1;
        iss_rs2  <= in_rs2;
        iss_addr <= in_addr;
        if (issue_cnt != '1) issue_cnt <= issue_cnt + 1'b1;
      end

      if (accept && !legal) illegal <= 1'b1;
      if (stall_evt && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;

      // Three drain cycles cover write-back of an instruction accepted just before halt.
      case (state)
        RUN: begin
          if (halt) begin
            state     <= DRAIN;
            drain_cnt <= 2'd3;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd1) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        DONE:    ;
        default: state <= RUN;
      endcase
    end
  end

endmodule
